// File: rtl/div_pkg.sv
// Shared types and constants for the sequential unsigned divider.
// Provides the FSM state encoding and the default operand width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH = 64;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

endpackage

// File: rtl/fullAdder.sv
// One-bit full adder cell used to build ripple arithmetic chains.
// Ports: a, b, cin in; sum, cout out.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/subtractor_64.sv
// Ripple subtractor a - b made of fullAdder cells (a + ~b + 1).
// Ports: a_i, b_i operands; diff_o difference; borrow_o set when a < b.
module subtractor_64 #(
    parameter int W = 65
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] c;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_fa
        fullAdder u_fa (
            .a    (a_i[i]),
            .b    (~b_i[i]),
            .cin  (c[i]),
            .sum  (diff_o[i]),
            .cout (c[i+1])
        );
    end

    // No carry out of the chain means the subtraction wrapped.
    assign borrow_o = ~c[W];

endmodule

// File: rtl/udiv_64_seq.sv
// Restoring shift-subtract unsigned divider, one quotient bit per cycle.
// Ports: clk, reset_n; start/dividend/divisor in; busy/done, quotient/remainder/div_by_zero out.
module udiv_64_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             diff_msb_unused;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] rem_nx;

    // Full rem register plus the incoming dividend bit; one extra bit
    // keeps shifted from overflowing when the divisor is above 2^(W-1).
    assign shifted = {rem_q, q_q[WIDTH-1]};

    subtractor_64 #(
        .W (WIDTH + 1)
    ) u_sub (
        .a_i      (shifted),
        .b_i      ({1'b0, dvsr_q}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    // The remainder always fits in WIDTH bits after restore/subtract.
    assign diff_msb_unused = diff[WIDTH];
    assign q_nx   = {q_q[WIDTH-2:0], ~borrow};
    assign rem_nx = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        dvsr_d  = dvsr_q;
        q_d     = q_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    dvsr_d = divisor;
                    q_d    = dividend;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '0;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                q_d   = q_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    quo_d   = q_nx;
                    rmd_d   = rem_nx;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dvsr_q  <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvsr_q  <= dvsr_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule
